// File: rtl/score_display_ctrl.sv
// Two-digit seven-segment score display: live score during play, flashing final
// score on game completion, then the steady high score until the next game.
module score_display_ctrl #(
   parameter int FLASH_PERIOD  = 6_000_000,
   parameter int FLASH_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] bcd_ones,
   input  logic [3:0] bcd_tens,
   input  logic       isGameComplete,
   output logic [6:0] seg_ones,
   output logic [6:0] seg_tens,
   output logic       final_active
);

   localparam int HW = $clog2(FLASH_PERIOD + 1);
   localparam int TW = $clog2(FLASH_TOGGLES + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(FLASH_PERIOD - 1);
   localparam logic [TW-1:0] TOG_LAST  = TW'(FLASH_TOGGLES - 1);

   localparam logic [1:0] ST_PLAY  = 2'd0;
   localparam logic [1:0] ST_FLASH = 2'd1;
   localparam logic [1:0] ST_HIGH  = 2'd2;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h40;
      endcase
   endfunction

   function automatic logic [6:0] tens_glyph(input logic [3:0] d);
      tens_glyph = (d == 4'd0) ? 7'h00 : glyph(d);
   endfunction

   logic [1:0]    state, state_nxt;
   logic [HW-1:0] half_cnt, half_nxt;
   logic [TW-1:0] tog_cnt, tog_nxt;
   logic          visible, vis_nxt;
   logic [3:0]    prev_ones, prev_tens;
   logic          prev_done;
   logic [3:0]    fin_ones, fin_tens, fin_ones_nxt, fin_tens_nxt;
   logic [6:0]    seg_ones_nxt, seg_tens_nxt;
   logic          final_nxt;
   logic          rise;

   // On the rising edge of isGameComplete the inputs already show the high
   // score, so the score just achieved comes from the previous-cycle copy.
   assign rise = isGameComplete & ~prev_done;

   always_comb begin
      state_nxt    = state;
      half_nxt     = half_cnt;
      tog_nxt      = tog_cnt;
      vis_nxt      = visible;
      fin_ones_nxt = fin_ones;
      fin_tens_nxt = fin_tens;
      if (!isGameComplete) begin
         state_nxt = ST_PLAY;
         half_nxt  = '0;
         tog_nxt   = '0;
         vis_nxt   = 1'b1;
      end else begin
         case (state)
            ST_PLAY: begin
               if (rise) begin
                  state_nxt    = ST_FLASH;
                  fin_ones_nxt = prev_ones;
                  fin_tens_nxt = prev_tens;
                  half_nxt     = '0;
                  tog_nxt      = '0;
                  vis_nxt      = 1'b1;
               end
            end
            ST_FLASH: begin
               if (half_cnt == HALF_LAST) begin
                  half_nxt = '0;
                  tog_nxt  = tog_cnt + TW'(1);
                  if (tog_cnt == TOG_LAST) begin
                     state_nxt = ST_HIGH;
                     vis_nxt   = 1'b1;
                  end else begin
                     vis_nxt = ~visible;
                  end
               end else begin
                  half_nxt = half_cnt + HW'(1);
               end
            end
            ST_HIGH: state_nxt = ST_HIGH;
            default: state_nxt = ST_PLAY;
         endcase
      end
   end

   // Output select stage: segments follow the state being entered this edge.
   always_comb begin
      final_nxt    = 1'b0;
      seg_ones_nxt = glyph(bcd_ones);
      seg_tens_nxt = tens_glyph(bcd_tens);
      if (state_nxt == ST_FLASH) begin
         final_nxt = 1'b1;
         if (vis_nxt) begin
            seg_ones_nxt = glyph(fin_ones_nxt);
            seg_tens_nxt = tens_glyph(fin_tens_nxt);
         end else begin
            seg_ones_nxt = 7'h00;
            seg_tens_nxt = 7'h00;
         end
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state        <= ST_PLAY;
         half_cnt     <= '0;
         tog_cnt      <= '0;
         visible      <= 1'b1;
         prev_ones    <= 4'd0;
         prev_tens    <= 4'd0;
         prev_done    <= 1'b0;
         seg_ones     <= 7'h3F;
         seg_tens     <= 7'h00;
         final_active <= 1'b0;
      end else begin
         state        <= state_nxt;
         half_cnt     <= half_nxt;
         tog_cnt      <= tog_nxt;
         visible      <= vis_nxt;
         prev_ones    <= bcd_ones;
         prev_tens    <= bcd_tens;
         prev_done    <= isGameComplete;
         seg_ones     <= seg_ones_nxt;
         seg_tens     <= seg_tens_nxt;
         final_active <= final_nxt;
      end
   end

   // Latched final score is pure data and only read while flashing.
   always_ff @(posedge clk) begin
      fin_ones <= fin_ones_nxt;
      fin_tens <= fin_tens_nxt;
   end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: a cycle-level reference model pushes
// expected outputs per clock edge; a monitor pops and compares on the falling edge.
module tb_score_display_ctrl;

   localparam int P = 4;
   localparam int T = 4;

   logic       clk = 1'b0;
   logic       nRst;
   logic [3:0] bcd_ones, bcd_tens;
   logic       isGameComplete;
   logic [6:0] seg_ones, seg_tens;
   logic       final_active;

   score_display_ctrl #(.FLASH_PERIOD(P), .FLASH_TOGGLES(T)) dut (
      .clk(clk), .nRst(nRst), .bcd_ones(bcd_ones), .bcd_tens(bcd_tens),
      .isGameComplete(isGameComplete), .seg_ones(seg_ones), .seg_tens(seg_tens),
      .final_active(final_active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [14:0] exp_q[$];

   logic [6:0] lut [16];
   initial begin
      lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
   end

   // Reference model: flashing flag plus cycles elapsed since the flash began.
   bit         m_flashing;
   int         m_elapsed;
   logic       m_pg;
   logic [3:0] m_po, m_pt, m_fo, m_ft;

   function automatic logic [6:0] tg(input logic [3:0] d);
      return (d == 4'd0) ? 7'h00 : lut[d];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic step(input logic gc, input logic [3:0] t, input logic [3:0] o);
      logic [14:0] e;
      isGameComplete = gc;
      bcd_tens = t;
      bcd_ones = o;
      if (!nRst) begin
         m_flashing = 0; m_pg = 0; m_po = 0; m_pt = 0;
         e = {7'h3F, 7'h00, 1'b0};
      end else begin
         if (!gc) m_flashing = 0;
         else if (!m_pg) begin
            m_flashing = 1; m_fo = m_po; m_ft = m_pt; m_elapsed = 0;
         end else if (m_flashing) begin
            m_elapsed++;
            if (m_elapsed >= P * T) m_flashing = 0;
         end
         if (m_flashing)
            e = (((m_elapsed / P) % 2) == 0) ? {lut[m_fo], tg(m_ft), 1'b1} : {7'h00, 7'h00, 1'b1};
         else
            e = {lut[o], tg(t), 1'b0};
         m_pg = gc; m_po = o; m_pt = t;
      end
      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   initial begin : monitor
      logic [14:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg_ones", 32'(seg_ones), 32'(e[14:8]));
            chk("seg_tens", 32'(seg_tens), 32'(e[7:1]));
            chk("final_active", 32'(final_active), 32'(e[0]));
         end
      end
   end

   initial begin : stim
      logic g;
      nRst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'bx, 4'bxxxx, 4'bxxxx);
      nRst = 1'b1;

      step(0, 2, 3);
      step(0, 0, 7);

      step(0, 1, 7); step(0, 1, 7);
      for (int i = 0; i < 21; i++) step(1, 2, 3);

      step(0, 5, 5); step(0, 5, 5);
      for (int i = 0; i < 6; i++) step(1, 4, 2);
      step(0, 4, 2); step(0, 3, 1);
      for (int i = 0; i < 19; i++) step(1, 9, 9);

      step(0, 4'hF, 4'hA);
      step(0, 0, 0);

      step(0, 1, 2);
      for (int i = 0; i < 4; i++) step(1, 3, 4);
      @(negedge clk); #1;
      nRst = 1'b0;
      #1;
      chk("async_rst_ones", 32'(seg_ones), 32'h3F);
      chk("async_rst_tens", 32'(seg_tens), 32'h00);
      chk("async_rst_fa", 32'(final_active), 32'h0);
      @(posedge clk); #1;
      step(1, 3, 4); step(1, 3, 4);
      nRst = 1'b1;
      step(0, 5, 8); step(0, 0, 9);
      for (int i = 0; i < 6; i++) step(1, 6, 6);

      g = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 29) == 0) g = ~g;
         step(g, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      @(negedge clk); #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
